// File: rtl/encrypt_rq_seq_if.sv
// Handshake and operand bus for the sequential NTRU-HRSS encrypt core.
// The lift stage drives it as master; the encrypt core is the slave.
interface encrypt_rq_seq_if #(
  parameter int N      = 701,
  parameter int Q_BITS = 13
);
  logic                start;
  logic [2*N-1:0]      r;
  logic [N*Q_BITS-1:0] h;
  logic [N*Q_BITS-1:0] m;
  logic                busy;
  logic                done;
  logic [N*Q_BITS-1:0] c;

  modport master (output start, r, h, m, input busy, done, c);
  modport slave  (input start, r, h, m, output busy, done, c);
endinterface

// File: rtl/encrypt_rq_seq.sv
// Sequential ciphertext core: c = r*h + m in Z_(2^Q_BITS)[x]/(x^N - 1).
// r is ternary. Latency is fixed at N*N/LANES MAC cycles plus one finish cycle.
module encrypt_rq_seq #(
  parameter int N      = 701,
  parameter int Q_BITS = 13,
  parameter int LANES  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  encrypt_rq_seq_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = IW + 1;

  if ((LANES < 1) || (N % LANES != 0)) begin : g_lanes_check
    $error("encrypt_rq_seq: LANES must divide N");
  end

  typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;

  state_t              state, state_nxt;
  logic [1:0]          r_q      [N];
  logic [Q_BITS-1:0]   h_q      [N];
  logic [Q_BITS-1:0]   acc      [N];
  logic [Q_BITS-1:0]   acc_nxt  [N];
  logic [SW-1:0]       lane_j   [LANES];
  logic [SW-1:0]       lane_idx [LANES];
  logic [IW-1:0]       i, j;
  logic [N*Q_BITS-1:0] c_q;
  logic                row_end, last_mac;

  // Ternary multiply-accumulate; the code 10 is treated as zero.
  function automatic logic [Q_BITS-1:0] mac_term(input logic [Q_BITS-1:0] a,
                                                 input logic [Q_BITS-1:0] b,
                                                 input logic [1:0]        code);
    case (code)
      2'b01:   mac_term = a + b;
      2'b11:   mac_term = a - b;
      default: mac_term = a;
    endcase
  endfunction

  assign row_end  = (({1'b0, j} + SW'(LANES)) == SW'(N));
  assign last_mac = (state == MAC) && row_end && (i == IW'(N - 1));
  assign bus.c    = c_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = MAC;
      MAC: begin
        bus.busy = 1'b1;
        if (last_mac) state_nxt = FIN;
      end
      FIN: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Target index (i + jj) mod N by one conditional subtract, since i + jj <= 2N-2.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_j[l]   = {1'b0, j} + SW'(l);
      lane_idx[l] = {1'b0, i} + lane_j[l];
      if (lane_idx[l] >= SW'(N)) lane_idx[l] = lane_idx[l] - SW'(N);
    end
  end

  // Lanes hit distinct accumulators in a cycle, so each write is conflict-free.
  always_comb begin
    for (int k = 0; k < N; k++) acc_nxt[k] = acc[k];
    if (state == MAC) begin
      for (int l = 0; l < LANES; l++) begin
        acc_nxt[lane_idx[l][IW-1:0]] = mac_term(acc[lane_idx[l][IW-1:0]],
                                                h_q[lane_j[l][IW-1:0]], r_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i   <= '0;
      j   <= '0;
      c_q <= '0;
      for (int k = 0; k < N; k++) begin
        r_q[k] <= '0;
        h_q[k] <= '0;
        acc[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            i <= '0;
            j <= '0;
            for (int k = 0; k < N; k++) begin
              r_q[k] <= bus.r[2*k +: 2];
              h_q[k] <= bus.h[k*Q_BITS +: Q_BITS];
              acc[k] <= bus.m[k*Q_BITS +: Q_BITS];
            end
          end
        end
        MAC: begin
          for (int k = 0; k < N; k++) acc[k] <= acc_nxt[k];
          if (row_end) begin
            j <= '0;
            i <= last_mac ? '0 : i + IW'(1);
          end else begin
            j <= j + IW'(LANES);
          end
          // The result lands on the same edge that enters FIN, so done and c align.
          if (last_mac) begin
            for (int k = 0; k < N; k++) c_q[k*Q_BITS +: Q_BITS] <= acc_nxt[k];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_encrypt_rq_seq.sv
// Bench for encrypt_rq_seq: N=7, q=8192, one single-lane and one seven-lane instance,
// checked every cycle against a polynomial-convolution reference plus literal vectors.
`timescale 1ns/1ps
module tb_encrypt_rq_seq;
  localparam int N  = 7;
  localparam int Q  = 13;
  localparam int QM = 8192;

  typedef logic [N*Q-1:0] poly_t;
  typedef logic [2*N-1:0] tern_t;
  typedef int             coef_t [N];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encrypt_rq_seq_if #(.N(N), .Q_BITS(Q)) if0 ();
  encrypt_rq_seq_if #(.N(N), .Q_BITS(Q)) if1 ();

  encrypt_rq_seq #(.N(N), .Q_BITS(Q), .LANES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  encrypt_rq_seq #(.N(N), .Q_BITS(Q), .LANES(7)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input poly_t got, input poly_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chkb(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic poly_t pq(input coef_t v);
    poly_t p = '0;
    for (int k = 0; k < N; k++) p[k*Q +: Q] = Q'(v[k]);
    return p;
  endfunction

  // Coefficient values: 1, -1, 0, and 2 standing for the unused code 10.
  function automatic tern_t pr(input coef_t v);
    tern_t p = '0;
    for (int k = 0; k < N; k++)
      case (v[k])
        1:       p[2*k +: 2] = 2'b01;
        -1:      p[2*k +: 2] = 2'b11;
        2:       p[2*k +: 2] = 2'b10;
        default: p[2*k +: 2] = 2'b00;
      endcase
    return p;
  endfunction

  function automatic int tval(input logic [1:0] code);
    return (code == 2'b01) ? 1 : (code == 2'b11) ? -1 : 0;
  endfunction

  // Reference: schoolbook cyclic convolution with integer sums, reduced at the end.
  function automatic poly_t model(input tern_t rr, input poly_t hh, input poly_t mm);
    int    s [N];
    poly_t p = '0;
    for (int k = 0; k < N; k++) s[k] = int'(mm[k*Q +: Q]);
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++)
        s[(a + b) % N] += tval(rr[2*a +: 2]) * int'(hh[b*Q +: Q]);
    for (int k = 0; k < N; k++) p[k*Q +: Q] = Q'(((s[k] % QM) + QM) % QM);
    return p;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? N * N : N;
  endfunction

  bit    act    [2];
  int    s_edge [2];
  poly_t exp_c  [2];
  poly_t exp_n  [2];

  // Per-cycle expectation: busy on cycles 1..L after acceptance, done on L+1, c held otherwise.
  task automatic mon(input int d, input logic st, input tern_t rr, input poly_t hh,
                     input poly_t mm, input logic busy, input logic done, input poly_t c);
    int k;
    bit fin = 0;
    if (!rst_n) begin
      chkb($sformatf("rst_busy%0d", d), busy, 1'b0);
      chkb($sformatf("rst_done%0d", d), done, 1'b0);
      chk($sformatf("rst_c%0d", d), c, '0);
      act[d]   = 0;
      exp_c[d] = '0;
      return;
    end
    if (act[d]) begin
      k = cyc + 1 - s_edge[d];
      chkb($sformatf("busy%0d_k%0d", d, k), busy, (k >= 1) && (k <= lat(d)));
      chkb($sformatf("done%0d_k%0d", d, k), done, k == lat(d) + 1);
      if (k >= lat(d) + 1) begin
        exp_c[d] = exp_n[d];
        act[d]   = 0;
        fin      = 1;
      end
    end else begin
      chkb($sformatf("idle_busy%0d", d), busy, 1'b0);
      chkb($sformatf("idle_done%0d", d), done, 1'b0);
    end
    chk($sformatf("c%0d", d), c, exp_c[d]);
    if (!act[d] && !fin && st) begin
      act[d]    = 1;
      s_edge[d] = cyc + 1;
      exp_n[d]  = model(rr, hh, mm);
    end
  endtask

  always @(negedge clk) begin
    mon(0, if0.start, if0.r, if0.h, if0.m, if0.busy, if0.done, if0.c);
    mon(1, if1.start, if1.r, if1.h, if1.m, if1.busy, if1.done, if1.c);
  end

  task automatic drive(input int d, input logic st, input tern_t rr, input poly_t hh, input poly_t mm);
    if (d == 0) begin
      if0.start = st; if0.r = rr; if0.h = hh; if0.m = mm;
    end else begin
      if1.start = st; if1.r = rr; if1.h = hh; if1.m = mm;
    end
  endtask

  function automatic logic get_done(input int d);
    return (d == 0) ? if0.done : if1.done;
  endfunction

  function automatic poly_t get_c(input int d);
    return (d == 0) ? if0.c : if1.c;
  endfunction

  // One operation; mode 1 re-pulses start with altered operands at cycles 3 and 20.
  task automatic run(input int d, input tern_t rr, input poly_t hh, input poly_t mm,
                     input int mode, output int lat_o);
    @(posedge clk); #2;
    drive(d, 1'b1, rr, hh, mm);
    @(posedge clk); #2;
    drive(d, 1'b0, rr, hh, mm);
    lat_o = 0;
    for (int n = 1; n <= 100; n++) begin
      if (mode == 1) drive(d, (n == 3) || (n == 20), ~rr, ~hh, hh);
      @(negedge clk);
      if (get_done(d)) begin
        lat_o = n;
        break;
      end
      @(posedge clk); #2;
    end
    chkb($sformatf("done_seen%0d", d), lat_o != 0, 1'b1);
  endtask

  initial begin
    coef_t hv, mv, rv, zv, ev;
    tern_t rr;
    poly_t hh, mm;
    int    lat_v, ndone;

    for (int k = 0; k < N; k++) zv[k] = 0;
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #2;
    chkb("reset_busy", if0.busy, 1'b0);
    chkb("reset_done", if0.done, 1'b0);
    chk("reset_c", if0.c, '0);
    rst_n = 1'b1;

    // r = x^0: c equals h.
    hv = '{1, 2, 3, 4, 5, 6, 7};
    rv = '{1, 0, 0, 0, 0, 0, 0};
    run(0, pr(rv), pq(hv), pq(zv), 0, lat_v);
    chki("t1_latency", lat_v, 50);
    chk("t1_c", get_c(0), pq(hv));

    // r = x^1: cyclic rotation.
    rv = '{0, 1, 0, 0, 0, 0, 0};
    ev = '{7, 1, 2, 3, 4, 5, 6};
    run(0, pr(rv), pq(hv), pq(zv), 0, lat_v);
    chk("t2_rot", get_c(0), pq(ev));

    // r = -x^0: negation mod 8192.
    rv = '{-1, 0, 0, 0, 0, 0, 0};
    ev = '{8191, 8190, 8189, 8188, 8187, 8186, 8185};
    run(0, pr(rv), pq(hv), pq(zv), 0, lat_v);
    chk("t2_neg", get_c(0), pq(ev));

    // 8191 + 1 wraps to 0.
    hv = '{8191, 0, 0, 0, 0, 0, 0};
    mv = '{1, 0, 0, 0, 0, 0, 0};
    rv = '{1, 0, 0, 0, 0, 0, 0};
    run(0, pr(rv), pq(hv), pq(mv), 0, lat_v);
    chk("t3_wrap", get_c(0), pq(zv));

    // Code 10 acts as zero, leaving c = m.
    hv = '{1, 2, 3, 4, 5, 6, 7};
    mv = '{5, 6, 7, 8, 9, 10, 11};
    rv = '{2, 0, 0, 0, 0, 0, 0};
    run(0, pr(rv), pq(hv), pq(mv), 0, lat_v);
    chk("t3_code10", get_c(0), pq(mv));

    // Seven lanes: random operands against the reference.
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < N; k++) begin
        rv[k] = int'($urandom_range(0, 2)) - 1;
        hv[k] = int'($urandom_range(0, QM - 1));
        mv[k] = int'($urandom_range(0, QM - 1));
      end
      rr = pr(rv); hh = pq(hv); mm = pq(mv);
      run(1, rr, hh, mm, 0, lat_v);
      chki($sformatf("t4_lat_%0d", t), lat_v, 8);
      chk($sformatf("t4_c_%0d", t), get_c(1), model(rr, hh, mm));
    end

    // Latency does not depend on r.
    hv = '{1, 2, 3, 4, 5, 6, 7};
    run(1, pr(zv), pq(hv), pq(mv), 0, lat_v);
    chki("t4_lat_zero", lat_v, 8);
    chk("t4_c_zero", get_c(1), pq(mv));
    rv = '{-1, -1, -1, -1, -1, -1, -1};
    ev = '{8164, 8164, 8164, 8164, 8164, 8164, 8164};
    run(1, pr(rv), pq(hv), pq(zv), 0, lat_v);
    chki("t4_lat_neg", lat_v, 8);
    chk("t4_c_neg", get_c(1), pq(ev));

    // Start pulses and operand changes while busy are ignored.
    rv = '{0, 1, 0, 0, 0, 0, 0};
    ev = '{7, 1, 2, 3, 4, 5, 6};
    run(0, pr(rv), pq(hv), pq(zv), 1, lat_v);
    chki("t5_latency", lat_v, 50);
    chk("t5_c", get_c(0), pq(ev));

    // Reset at MAC cycle 10 abandons the operation.
    rv = '{-1, 0, 0, 0, 0, 0, 0};
    @(posedge clk); #2;
    drive(0, 1'b1, pr(rv), pq(hv), pq(zv));
    @(posedge clk); #2;
    drive(0, 1'b0, pr(rv), pq(hv), pq(zv));
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chkb("t6_busy", if0.busy, 1'b0);
    chkb("t6_done", if0.done, 1'b0);
    chk("t6_c", if0.c, '0);
    chk("t6_c1", if1.c, '0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (if0.done) ndone++;
    end
    chki("t6_no_done", ndone, 0);
    rv = '{1, 0, 0, 0, 0, 0, 0};
    run(0, pr(rv), pq(hv), pq(zv), 0, lat_v);
    chki("t6_latency", lat_v, 50);
    chk("t6_c_after", get_c(0), pq(hv));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
